divider_4bit: RTL and testbench

DIVIDER_4BIT -- requirements
Module: divider_4bit

---
 rtl/divider_pkg.sv | 9 +
 rtl/div_step.sv | 14 +
 rtl/divider_4bit.sv | 103 ++++++++++
 tb/tb_divider_4bit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM encoding and default width for the restoring divider
package divider_pkg;
    localparam int DEF_WIDTH = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring compare/subtract on an already-shifted remainder
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    assign q_bit    = rem_i >= {1'b0, dvs_i};
    assign rem_next = q_bit ? rem_i - {1'b0, dvs_i} : rem_i;
endmodule

// File: rtl/divider_4bit.sv
// divider_4bit: multi-cycle unsigned restoring divider, one quotient bit per RUN cycle
module divider_4bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d, r_sh, rem_next;
    logic [WIDTH-1:0] wq_q, wq_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d, wq_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d, q_bit;
    logic             unused_msb;

    // The top remainder bit is always 0 after a restore, so the shift drops it.
    assign r_sh       = {r_q[WIDTH-1:0], wq_q[WIDTH-1]};
    assign wq_next    = {wq_q[WIDTH-2:0], q_bit};
    assign unused_msb = r_q[WIDTH];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i   (r_sh),
        .dvs_i   (dvs_q),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        wq_d    = wq_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        if (state_q != RUN && start) begin
            dvs_d = Divisor;
            r_d   = '0;
            wq_d  = Dividend;
            cnt_d = '0;
            if (Divisor == '0) begin
                state_d = DONE;
                quo_d   = '1;
                rem_d   = Dividend;
                dz_d    = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            r_d   = rem_next;
            wq_d  = wq_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                quo_d   = wq_next;
                rem_d   = rem_next[WIDTH-1:0];
                dz_d    = 1'b0;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            wq_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            wq_q    <= wq_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = state_q == RUN;
    assign done      = state_q == DONE;
    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign DivZero   = dz_q;
endmodule

// File: tb/tb_divider_4bit.sv
// tb_divider_4bit: directed and random divisions checked against plain / and % arithmetic
module tb_divider_4bit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] Dividend = '0;
    logic [3:0] Divisor = '0;
    logic       busy, done, DivZero;
    logic [3:0] Quotient, Remainder;
    int         n_tests = 0;
    int         n_fail = 0;

    divider_4bit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .busy     (busy),
        .done     (done),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .DivZero  (DivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts negedges after the accepting edge until done, optionally pulsing a rogue start mid-run.
    task automatic wait_done(input bit inject, output int lat, output int nbusy);
        lat = 0;
        nbusy = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) break;
            if (inject && lat == 1) begin
                start = 1'b1; Dividend = 4'd15; Divisor = 4'd15;
            end else if (inject && lat == 2) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic expect_result(input string tag, input logic [3:0] a, input logic [3:0] b);
        check({tag, "_q"}, 32'(Quotient), 32'((b == 0) ? 4'hF : a / b));
        check({tag, "_r"}, 32'(Remainder), 32'((b == 0) ? a : a % b));
        check({tag, "_dz"}, 32'(DivZero), 32'(b == 0));
    endtask

    task automatic accept(input logic [3:0] a, input logic [3:0] b);
        Dividend = a; Divisor = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        Dividend = 4'($urandom); Divisor = 4'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b);
        int lat, nb;
        @(negedge clk);
        accept(a, b);
        wait_done(1'b0, lat, nb);
        check({tag, "_lat"}, 32'(lat), (b == 0) ? 32'd1 : 32'd5);
        check({tag, "_busy"}, 32'(nb), (b == 0) ? 32'd0 : 32'd4);
        expect_result(tag, a, b);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        expect_result({tag, "_hold"}, a, b);
    endtask

    initial begin
        int lat, nb, ndone;
        #1 rst = 1'b1;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(Quotient), 0);
        check("rst_r", 32'(Remainder), 0);
        check("rst_dz", 32'(DivZero), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("d13_3", 4'd13, 4'd3);
        run_op("d15_1", 4'd15, 4'd1);
        run_op("d2_5", 4'd2, 4'd5);
        run_op("d7_0", 4'd7, 4'd0);

        // A second start while busy must not disturb the in-flight 9/2.
        @(negedge clk);
        accept(4'd9, 4'd2);
        wait_done(1'b1, lat, nb);
        check("ign_lat", 32'(lat), 32'd5);
        expect_result("ign", 4'd9, 4'd2);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ign_extra_done", 32'(ndone), 0);

        // Back-to-back: start presented during the DONE cycle.
        @(negedge clk);
        accept(4'd12, 4'd4);
        wait_done(1'b0, lat, nb);
        check("b2b1_lat", 32'(lat), 32'd5);
        expect_result("b2b1", 4'd12, 4'd4);
        accept(4'd11, 4'd3);
        wait_done(1'b0, lat, nb);
        check("b2b2_lat", 32'(lat), 32'd5);
        check("b2b2_busy", 32'(nb), 32'd4);
        expect_result("b2b2", 4'd11, 4'd3);

        // Asynchronous abort in the second RUN cycle.
        @(negedge clk);
        accept(4'd9, 4'd2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_q", 32'(Quotient), 0);
        check("abort_r", 32'(Remainder), 0);
        check("abort_dz", 32'(DivZero), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_quiet", 32'(ndone), 0);
        run_op("d6_4", 4'd6, 4'd4);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom_range(0, 15));
            b = (i % 8 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
